// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states,
// and the request legality/alignment check.
package mem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   // Unsigned loads have no store counterpart, so BU/HU are illegal for stores.
   function automatic logic req_bad(input logic wr, input logic [2:0] f3, input logic [1:0] a_lo);
      logic bad;
      bad = 1'b1;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_BU:   bad = wr;
         F3_H:    bad = a_lo[0];
         F3_HU:   bad = wr | a_lo[0];
         F3_W:    bad = (a_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_store_merge.sv
// Byte/half-word lane insertion for read-modify-write stores.
module mem_access_unit_store_merge
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [15:0] wdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  a_lo,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      if (funct3 == F3_B) begin
         case (a_lo)
            2'd0: merged[7:0]   = wdata[7:0];
            2'd1: merged[15:8]  = wdata[7:0];
            2'd2: merged[23:16] = wdata[7:0];
            default: merged[31:24] = wdata[7:0];
         endcase
      end else if (funct3 == F3_H) begin
         if (a_lo[1]) merged[31:16] = wdata;
         else         merged[15:0]  = wdata;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM-stage request and a word-wide datamem:
// alignment checks, read-modify-write for sub-word stores, right-justified loads.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata
);

   state_t            state_q, state_nxt;
   logic              accept;
   logic [2:0]        f3_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merged;
   logic [4:0]        shamt;

   assign accept   = req_valid && req_ready;
   assign mem_addr = addr_q[ADDR_W+1:2];
   assign shamt    = {addr_q[1:0], 3'b000};

   always_comb begin
      state_nxt = state_q;
      req_ready = (state_q == ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_bad(req_write, req_funct3, req_addr[1:0])) state_nxt = ST_ERR;
               else if (!req_write)                               state_nxt = ST_LOAD;
               else if (req_funct3 == F3_W)                       state_nxt = ST_WRITE;
               else                                               state_nxt = ST_MERGE;
            end
         end
         ST_LOAD:  state_nxt = ST_RESP;
         ST_MERGE: state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         ST_ERR:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_nxt;
   end

   // Word index stays visible on mem_addr from accept until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         addr_q <= '0;
      else if (accept) addr_q <= req_addr;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         f3_q    <= req_funct3;
         wdata_q <= req_wdata;
      end
   end

   mem_access_unit_store_merge u_merge (
      .old_word (mem_rdata),
      .wdata    (wdata_q[15:0]),
      .funct3   (f3_q),
      .a_lo     (addr_q[1:0]),
      .merged   (merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_write <= 1'b0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         mem_write <= (state_nxt == ST_WRITE);
         rsp_valid <= (state_nxt == ST_RESP) || (state_nxt == ST_ERR);
         if (state_q == ST_MERGE)        mem_wdata <= merged;
         else if (accept && req_write)   mem_wdata <= req_wdata;
         if (state_nxt == ST_ERR) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
         end else if (state_q == ST_LOAD) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_rdata >> shamt;
         end else if (state_q == ST_WRITE) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide datamem.
module tb_mem_access_unit;

   localparam int ADDR_W = 12;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W+1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_write;
   logic [31:0]       mem_rdata;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_rdata  (rsp_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one request and observes 8 cycles after the accept edge.
   task automatic run_req(input logic w, input logic [2:0] f3, input logic [ADDR_W+1:0] a,
                          input logic [31:0] d, output int lat, output int nrsp,
                          output logic err, output logic [31:0] rd, output int nwr,
                          output logic [ADDR_W-1:0] wa, output logic [31:0] wd);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1; nrsp = 0; err = 1'bx; rd = 'x; nwr = 0; wa = 'x; wd = 'x;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_write) begin
            nwr++;
            wa = mem_addr;
            wd = mem_wdata;
         end
         if (rsp_valid) begin
            nrsp++;
            if (lat < 0) begin
               lat = c;
               err = rsp_err;
               rd  = rsp_rdata;
            end
         end
      end
   endtask

   int                lat, nrsp, nwr;
   logic              err;
   logic [31:0]       rd, wd;
   logic [ADDR_W-1:0] wa;
   int                seen;

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
      mem[7] = 32'hFFFF_FB00;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk) rst = 1'b0;

      // SW then LW at index 2
      run_req(1'b1, 3'b010, 14'h008, 32'h0000_0280, lat, nrsp, err, rd, nwr, wa, wd);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_nrsp", 32'(nrsp), 32'd1);
      chk("sw_err", 32'(err), 32'd0);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_nwr", 32'(nwr), 32'd1);
      chk("sw_waddr", 32'(wa), 32'd2);
      chk("sw_wdata", wd, 32'h0000_0280);
      chk("sw_mem2", mem[2], 32'h0000_0280);
      run_req(1'b0, 3'b010, 14'h008, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_err", 32'(err), 32'd0);
      chk("lw_rdata", rd, 32'h0000_0280);
      chk("lw_nwr", 32'(nwr), 32'd0);

      // SB into byte 1 of mem[7], then LBU
      run_req(1'b1, 3'b000, 14'h01D, 32'h0000_00AB, lat, nrsp, err, rd, nwr, wa, wd);
      chk("sb_lat", 32'(lat), 32'd3);
      chk("sb_err", 32'(err), 32'd0);
      chk("sb_nwr", 32'(nwr), 32'd1);
      chk("sb_waddr", 32'(wa), 32'd7);
      chk("sb_mem7", mem[7], 32'hFFFF_AB00);
      run_req(1'b0, 3'b100, 14'h01D, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("lbu_lat", 32'(lat), 32'd2);
      chk("lbu_rdata", rd, 32'h00FF_FFAB);

      // SH upper half, then LH / LB of the top byte
      run_req(1'b1, 3'b001, 14'h01E, 32'h0000_1234, lat, nrsp, err, rd, nwr, wa, wd);
      chk("sh_lat", 32'(lat), 32'd3);
      chk("sh_wdata", wd, 32'h1234_AB00);
      chk("sh_mem7", mem[7], 32'h1234_AB00);
      run_req(1'b0, 3'b001, 14'h01E, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("lh_rdata", rd, 32'h0000_1234);
      run_req(1'b0, 3'b000, 14'h01F, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("lb_rdata", rd, 32'h0000_0012);

      // Errors: misaligned LW, misaligned SH, illegal load funct3, illegal store funct3
      run_req(1'b0, 3'b010, 14'h009, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("err_lw_lat", 32'(lat), 32'd1);
      chk("err_lw_err", 32'(err), 32'd1);
      chk("err_lw_rdata", rd, 32'h0);
      run_req(1'b1, 3'b001, 14'h003, 32'hDEAD_BEEF, lat, nrsp, err, rd, nwr, wa, wd);
      chk("err_sh_lat", 32'(lat), 32'd1);
      chk("err_sh_err", 32'(err), 32'd1);
      chk("err_sh_nwr", 32'(nwr), 32'd0);
      chk("err_sh_mem0", mem[0], 32'h0);
      run_req(1'b0, 3'b011, 14'h008, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("err_f3_011_err", 32'(err), 32'd1);
      chk("err_f3_011_nrsp", 32'(nrsp), 32'd1);
      run_req(1'b1, 3'b100, 14'h008, 32'h5555_5555, lat, nrsp, err, rd, nwr, wa, wd);
      chk("err_sbu_err", 32'(err), 32'd1);
      chk("err_sbu_nwr", 32'(nwr), 32'd0);
      chk("err_mem2", mem[2], 32'h0000_0280);

      // Highest word index, no wrap
      run_req(1'b1, 3'b010, 14'h3FFC, 32'hCAFE_F00D, lat, nrsp, err, rd, nwr, wa, wd);
      chk("max_waddr", 32'(wa), 32'hFFF);
      run_req(1'b0, 3'b010, 14'h3FFC, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("max_rdata", rd, 32'hCAFE_F00D);
      chk("max_mem0", mem[0], 32'h0);

      // Reset during WRITE of an SB
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
      req_addr = 14'h01C; req_wdata = 32'h0000_0055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 0;
      @(negedge clk);
      if (rsp_valid) seen++;
      @(negedge clk);
      if (rsp_valid) seen++;
      chk("abort_in_write", 32'(mem_write), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_mem_write_async", 32'(mem_write), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      if (rsp_valid) seen++;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("abort_no_rsp", 32'(seen), 32'd0);
      chk("abort_mem7", mem[7], 32'h1234_AB00);
      run_req(1'b0, 3'b010, 14'h01C, 32'h0, lat, nrsp, err, rd, nwr, wa, wd);
      chk("post_abort_lw", rd, 32'h1234_AB00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
